// File: rtl/sram_bist_pkg.sv
// Shared types for the 1P SRAM March C- BIST engine:
// element/state enums and the per-element op table.
package sram_bist_pkg;

  typedef enum logic [2:0] {
    M0, M1, M2, M3, M4, M5
  } march_elem_e;

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_FIN
  } bist_state_e;

  typedef enum logic {
    OP_W = 1'b0,
    OP_R = 1'b1
  } bist_op_e;

  typedef struct packed {
    logic     down;
    logic     two_ops;
    bist_op_e op0;
    logic     pol0;
    bist_op_e op1;
    logic     pol1;
  } elem_cfg_t;

  localparam march_elem_e LAST_ELEM = M5;

  function automatic elem_cfg_t elem_cfg(
    input march_elem_e e
  );
    elem_cfg_t c;
    c = '{1'b0, 1'b0, OP_W, 1'b0, OP_W, 1'b0};
    case (e)
      M0: c = '{1'b0, 1'b0, OP_W, 1'b0, OP_W, 1'b0};
      M1: c = '{1'b0, 1'b1, OP_R, 1'b0, OP_W, 1'b1};
      M2: c = '{1'b0, 1'b1, OP_R, 1'b1, OP_W, 1'b0};
      M3: c = '{1'b1, 1'b1, OP_R, 1'b0, OP_W, 1'b1};
      M4: c = '{1'b1, 1'b1, OP_R, 1'b1, OP_W, 1'b0};
      M5: c = '{1'b1, 1'b0, OP_R, 1'b0, OP_W, 1'b0};
      default: c = '{1'b0, 1'b0, OP_W, 1'b0, OP_W, 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Loadable up/down address counter over 0..P_DEPTH-1
// with a last-address flag for the current direction.
module sram_bist_addr_gen #(
  parameter int P_ADDR_WIDTH = 8,
  parameter int P_DEPTH      = 256
) (
  input  logic                    A_CLK,
  input  logic                    A_RESET_N,
  input  logic                    load,
  input  logic                    load_down,
  input  logic                    step,
  input  logic                    dir_down,
  output logic [P_ADDR_WIDTH-1:0] addr,
  output logic                    last
);

  localparam logic [P_ADDR_WIDTH-1:0] TOP =
    P_ADDR_WIDTH'(P_DEPTH - 1);

  always_ff @(posedge A_CLK or negedge A_RESET_N) begin
    if (!A_RESET_N) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_down ? TOP : '0;
    end else if (step) begin
      addr <= dir_down ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign last = dir_down ? (addr == '0) : (addr == TOP);

endmodule

// File: rtl/sram_1p_march_bist.sv
// March C- BIST engine for the 1P SRAM macro family.
// Registered macro controls; compare two edges after issue.
module sram_1p_march_bist
  import sram_bist_pkg::*;
#(
  parameter int P_DATA_WIDTH   = 48,
  parameter int P_ADDR_WIDTH   = 8,
  parameter int P_DEPTH        = 256,
  parameter int P_STOP_ON_FAIL = 1
) (
  input  logic                    A_CLK,
  input  logic                    A_RESET_N,
  input  logic                    A_START,
  output logic                    A_BUSY,
  output logic                    A_DONE,
  output logic                    A_FAIL,
  output logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR,
  output logic [2:0]              A_FAIL_ELEM,
  output logic [P_DATA_WIDTH-1:0] A_FAIL_MASK,
  output logic                    A_BIST_EN,
  output logic                    A_BIST_MEN,
  output logic                    A_BIST_WEN,
  output logic                    A_BIST_REN,
  output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
  output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
  input  logic [P_DATA_WIDTH-1:0] A_DOUT
);

  localparam int DW = P_DATA_WIDTH;
  localparam int AW = P_ADDR_WIDTH;

  bist_state_e state_q, state_d;
  march_elem_e elem_q, elem_d, nxt_elem;
  logic phase_q, phase_d;
  logic ops_done_q, ops_done_d;
  logic abort_q, abort_d;

  logic en_q, en_d;
  logic men_q, men_d;
  logic wen_q, wen_d;
  logic ren_q, ren_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [DW-1:0] bm_q, bm_d;
  logic iss_pol_q, iss_pol_d;
  march_elem_e iss_elem_q, iss_elem_d;

  logic cmp_v_q, cmp_pol_q;
  march_elem_e cmp_elem_q;
  logic [AW-1:0] cmp_addr_q;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic fail_q, fail_d;
  logic [AW-1:0] fa_q, fa_d;
  march_elem_e fe_q, fe_d;
  logic [DW-1:0] fm_q, fm_d;

  elem_cfg_t cfg;
  bist_op_e op;
  logic pol;
  logic [DW-1:0] miss;
  logic mismatch;

  logic ag_load, ag_load_down, ag_step;
  logic [AW-1:0] ag_addr;
  logic ag_last;

  sram_bist_addr_gen #(
    .P_ADDR_WIDTH(AW),
    .P_DEPTH     (P_DEPTH)
  ) u_addr_gen (
    .A_CLK    (A_CLK),
    .A_RESET_N(A_RESET_N),
    .load     (ag_load),
    .load_down(ag_load_down),
    .step     (ag_step),
    .dir_down (cfg.down),
    .addr     (ag_addr),
    .last     (ag_last)
  );

  assign cfg      = elem_cfg(elem_q);
  assign nxt_elem = march_elem_e'(elem_q + 3'd1);
  assign op       = phase_q ? cfg.op1 : cfg.op0;
  assign pol      = phase_q ? cfg.pol1 : cfg.pol0;
  assign miss     = {DW{cmp_pol_q}} ^ A_DOUT;
  assign mismatch = cmp_v_q && (miss != '0) &&
                    (state_q == S_RUN || state_q == S_DRAIN);

  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    phase_d      = phase_q;
    ops_done_d   = ops_done_q;
    abort_d      = abort_q;
    en_d         = en_q;
    men_d        = 1'b0;
    wen_d        = 1'b0;
    ren_d        = 1'b0;
    addr_d       = addr_q;
    din_d        = '0;
    bm_d         = '0;
    iss_pol_d    = iss_pol_q;
    iss_elem_d   = iss_elem_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    fa_d         = fa_q;
    fe_d         = fe_q;
    fm_d         = fm_q;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_step      = 1'b0;

    if (mismatch) begin
      fail_d = 1'b1;
      if (!fail_q) begin
        fa_d = cmp_addr_q;
        fe_d = cmp_elem_q;
        fm_d = miss;
      end
      if (P_STOP_ON_FAIL != 0) abort_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE, S_FIN: begin
        addr_d = '0;
        if (A_START) begin
          state_d    = S_RUN;
          busy_d     = 1'b1;
          en_d       = 1'b1;
          done_d     = 1'b0;
          fail_d     = 1'b0;
          fa_d       = '0;
          fe_d       = M0;
          fm_d       = '0;
          elem_d     = M0;
          phase_d    = 1'b0;
          ops_done_d = 1'b0;
          abort_d    = 1'b0;
          ag_load    = 1'b1;
        end
      end
      S_RUN: begin
        if (abort_q) begin
          // the op issued at the mismatch edge has completed
          state_d = S_FIN;
          busy_d  = 1'b0;
          en_d    = 1'b0;
          done_d  = 1'b1;
          addr_d  = '0;
        end else if (ops_done_q) begin
          state_d = S_DRAIN;
        end else begin
          men_d      = 1'b1;
          wen_d      = (op == OP_W);
          ren_d      = (op == OP_R);
          din_d      = (op == OP_W) ? {DW{pol}} : '0;
          bm_d       = '1;
          addr_d     = ag_addr;
          iss_pol_d  = pol;
          iss_elem_d = elem_q;
          if (cfg.two_ops && !phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (!ag_last) begin
              ag_step = 1'b1;
            end else if (elem_q == LAST_ELEM) begin
              ops_done_d = 1'b1;
            end else begin
              elem_d       = nxt_elem;
              ag_load      = 1'b1;
              ag_load_down = elem_cfg(nxt_elem).down;
            end
          end
        end
      end
      S_DRAIN: begin
        state_d = S_FIN;
        busy_d  = 1'b0;
        en_d    = 1'b0;
        done_d  = 1'b1;
        addr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge A_CLK or negedge A_RESET_N) begin
    if (!A_RESET_N) begin
      state_q    <= S_IDLE;
      elem_q     <= M0;
      phase_q    <= 1'b0;
      ops_done_q <= 1'b0;
      abort_q    <= 1'b0;
      en_q       <= 1'b0;
      men_q      <= 1'b0;
      wen_q      <= 1'b0;
      ren_q      <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      bm_q       <= '0;
      iss_pol_q  <= 1'b0;
      iss_elem_q <= M0;
      cmp_v_q    <= 1'b0;
      cmp_pol_q  <= 1'b0;
      cmp_elem_q <= M0;
      cmp_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      fa_q       <= '0;
      fe_q       <= M0;
      fm_q       <= '0;
    end else begin
      state_q    <= state_d;
      elem_q     <= elem_d;
      phase_q    <= phase_d;
      ops_done_q <= ops_done_d;
      abort_q    <= abort_d;
      en_q       <= en_d;
      men_q      <= men_d;
      wen_q      <= wen_d;
      ren_q      <= ren_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      bm_q       <= bm_d;
      iss_pol_q  <= iss_pol_d;
      iss_elem_q <= iss_elem_d;
      cmp_v_q    <= ren_q;
      cmp_pol_q  <= iss_pol_q;
      cmp_elem_q <= iss_elem_q;
      cmp_addr_q <= addr_q;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      fa_q       <= fa_d;
      fe_q       <= fe_d;
      fm_q       <= fm_d;
    end
  end

  assign A_BUSY      = busy_q;
  assign A_DONE      = done_q;
  assign A_FAIL      = fail_q;
  assign A_FAIL_ADDR = fa_q;
  assign A_FAIL_ELEM = fe_q;
  assign A_FAIL_MASK = fm_q;
  assign A_BIST_EN   = en_q;
  assign A_BIST_MEN  = men_q;
  assign A_BIST_WEN  = wen_q;
  assign A_BIST_REN  = ren_q;
  assign A_BIST_ADDR = addr_q;
  assign A_BIST_DIN  = din_q;
  assign A_BIST_BM   = bm_q;

endmodule

// File: doc/sram_1p_march_bist.md
Name: sram_1p_march_bist

Overview:
- Parametrised March C- BIST engine for the 1P SRAM macro family with bit-mask BIST ports; runs on any macro width/depth.
- Drives the macro's A_BIST_* port group and checks read data on A_DOUT.
- Reports pass/fail plus first-failure address, element and bit mask.
- Sits beside each macro; the chip test controller starts it and reads the result.

Parameters:
P_DATA_WIDTH, 48, macro data width (DW)
P_ADDR_WIDTH, 8, macro address width (AW)
P_DEPTH, 256, number of words tested (addresses 0..P_DEPTH-1); must be <= 2**AW
P_STOP_ON_FAIL, 1, 1 = abort at first mismatch; 0 = run to completion and keep the first failure

Ports:
A_CLK  in  1  clock, shared with the macro's A_BIST_CLK
A_RESET_N  in  1  asynchronous active-low reset
A_START  in  1  start request, sampled on the rising edge when idle
A_BUSY  out  1  test in progress
A_DONE  out  1  test finished; held until the next accepted start
A_FAIL  out  1  sticky mismatch flag
A_FAIL_ADDR  out  AW  address of first mismatch
A_FAIL_ELEM  out  3  March element of first mismatch (0..5)
A_FAIL_MASK  out  DW  expected XOR read data at first mismatch
A_BIST_EN  out  1  selects BIST port group on the macro
A_BIST_MEN / A_BIST_WEN / A_BIST_REN  out  1 each  macro enables
A_BIST_ADDR  out  AW  macro address
A_BIST_DIN  out  DW  write data
A_BIST_BM  out  DW  bit mask
A_DOUT  in  DW  macro read data

Behaviour:
- Clock and reset: one clock (A_CLK); reset is asynchronous and active-low (A_RESET_N).
- Reset values: all outputs 0. Reset forces this immediately, including mid-run, and BIST_EN drops asynchronously.
- States: IDLE -> RUN -> DRAIN -> FIN.
  - FIN -> RUN on the next A_START.
  - IDLE and FIN ignore A_START while BUSY.
- A_START is accepted at edge 0. BUSY=1 and BIST_EN=1 from edge 0 until DONE rises.
- March C- elements, one macro op per cycle (each op is one clock):
  - M0: up, w0
  - M1: up, r0 then w1
  - M2: up, r1 then w0
  - M3: down, r0 then w1
  - M4: down, r1 then w0
  - M5: down, r0
- "up" runs 0..P_DEPTH-1; "down" runs P_DEPTH-1..0. The element advances after its last address and the counter reloads; no wrap into addresses >= P_DEPTH.
- Ops:
  - Write: MEN=1, WEN=1, REN=0, DIN = all-0 or all-1.
  - Read: MEN=1, REN=1, WEN=0.
  - BM all-ones on every op.
  - Between ops within RUN, MEN is never low.
- Compare: read data is checked at the edge after the read edge against a registered expected value, element and address.
  - Mismatch sets FAIL.
  - FAIL_ADDR, FAIL_ELEM and FAIL_MASK capture the first mismatch only.
- Timing:
  - RUN issues 10*P_DEPTH ops.
  - DRAIN is one cycle with MEN=0; it compares the final M5 read.
  - FIN: DONE=1, BUSY=0, BIST_EN=0, all macro enables 0.
  - With no abort, DONE rises at edge 10*P_DEPTH+2.
- Stop on fail (P_STOP_ON_FAIL=1):
  - At the mismatch edge the op issued at that same edge completes; no further op is issued.
  - Next state is FIN, not DRAIN; FAIL=1, DONE=1.
- A_START in FIN clears FAIL/DONE/capture registers at edge 0.

Decomposition:
- Package sram_bist_pkg holds:
  - the March element enum (3-bit, M0..M5)
  - the FSM state enum
  - the per-element table: direction, op count, first/second op type and data polarity
- Sub-module sram_bist_addr_gen: loadable up/down counter over 0..P_DEPTH-1 with a last-address flag.

Test Plan:
- Clean macro, default params, A_START pulse -> DONE at edge 2562, FAIL=0, exactly 1280 writes and 1280 reads, BIST_BM all-ones throughout.
- Bit 5 stuck-at-1 at address 0x3A, stop-on-fail -> FAIL=1, FAIL_ELEM=1, FAIL_ADDR=0x3A, FAIL_MASK=0x20, no ops after the abort edge.
- P_STOP_ON_FAIL=0, faults at 0x10 (bit 0 SA1) and 0x80 -> run completes at edge 2562, FAIL_ADDR=0x10, FAIL_MASK=0x1.
- A_RESET_N low mid-M3 -> all outputs 0 without a clock edge; the next A_START runs a full clean test to DONE.
- A_START pulses while BUSY -> ignored, DONE timing unchanged; P_DEPTH=200 -> ADDR never exceeds 199, DONE at edge 2002.
